// File: rtl/mesh_xy_router.sv
// mesh_xy_router: 5-port 2D-mesh router with dimension-ordered (X then Y)
// routing, a DEPTH-entry FIFO per input and a round-robin arbiter plus
// registered flit slot per output.
// Optional build macro MESH_XY_ROUTER_STATS_EN adds per-output flit counters
// on port stat_flits.
module mesh_xy_router #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned COORD_W = 4,
  parameter int unsigned X_ID    = 0,
  parameter int unsigned Y_ID    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5*DATA_W-1:0] in_data,
  input  logic [4:0]          in_valid,
  output logic [4:0]          in_ready,
  output logic [5*DATA_W-1:0] out_data,
  output logic [4:0]          out_valid,
  input  logic [4:0]          out_ready
`ifdef MESH_XY_ROUTER_STATS_EN
  ,
  output logic [5*32-1:0]     stat_flits
`endif
);

  localparam int unsigned NPORT  = 5;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned STAT_W = 32;

  localparam int unsigned P_LOCAL = 0;
  localparam int unsigned P_NORTH = 1;
  localparam int unsigned P_EAST  = 2;
  localparam int unsigned P_SOUTH = 3;
  localparam int unsigned P_WEST  = 4;

  // Input FIFO state
  logic [DATA_W-1:0] r_mem     [NPORT][DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr  [NPORT];
  logic [PTR_W-1:0]  r_rd_ptr  [NPORT];
  logic [CNT_W-1:0]  r_count   [NPORT];
  logic [CNT_W-1:0]  w_cnt_nxt [NPORT];
  logic [NPORT-1:0]  r_in_ready;

  logic [NPORT-1:0]  w_push;
  logic [NPORT-1:0]  w_pop;
  logic [NPORT-1:0]  w_nonempty;

  // Head-of-FIFO decode
  logic [DATA_W-1:0]  w_head  [NPORT];
  logic [COORD_W-1:0] w_dx    [NPORT];
  logic [COORD_W-1:0] w_dy    [NPORT];
  logic [NPORT-1:0]   w_route [NPORT];

  // Per-output arbitration
  logic [NPORT-1:0]  w_req     [NPORT];
  logic [NPORT-1:0]  w_free;
  logic [NPORT-1:0]  w_gnt_vld;
  logic [2:0]        w_gnt_idx [NPORT];
  logic [2:0]        r_rr_ptr  [NPORT];
  logic [3:0]        w_sum;
  logic [2:0]        w_cand;

  // Output registers
  logic [5*DATA_W-1:0] r_out_data;
  logic [NPORT-1:0]    r_out_valid;

  assign in_ready  = r_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

  // A flit enters when the sender offers it and the FIFO had room last cycle
  assign w_push = in_valid & r_in_ready;

  // Read the head of each FIFO and compute its X-first output direction
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      w_head[i]     = r_mem[i][r_rd_ptr[i]];
      w_nonempty[i] = (r_count[i] != '0);
      w_dx[i]       = w_head[i][DATA_W-1 -: COORD_W];
      w_dy[i]       = w_head[i][DATA_W-1-COORD_W -: COORD_W];
      w_route[i]    = '0;
      if (w_dx[i] > COORD_W'(X_ID)) begin
        w_route[i][P_EAST] = 1'b1;
      end else if (w_dx[i] < COORD_W'(X_ID)) begin
        w_route[i][P_WEST] = 1'b1;
      end else if (w_dy[i] > COORD_W'(Y_ID)) begin
        w_route[i][P_NORTH] = 1'b1;
      end else if (w_dy[i] < COORD_W'(Y_ID)) begin
        w_route[i][P_SOUTH] = 1'b1;
      end else begin
        w_route[i][P_LOCAL] = 1'b1;
      end
    end
  end

  // Transpose routes into per-output request vectors (bit i = input i)
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      for (int i = 0; i < NPORT; i++) begin
        w_req[o][i] = w_nonempty[i] & w_route[i][o];
      end
    end
  end

  // Round-robin search starting at each output's pointer, only when free
  always_comb begin
    w_sum  = '0;
    w_cand = '0;
    for (int o = 0; o < NPORT; o++) begin
      w_free[o]    = ~r_out_valid[o] | out_ready[o];
      w_gnt_vld[o] = 1'b0;
      w_gnt_idx[o] = '0;
      for (int k = 0; k < NPORT; k++) begin
        w_sum  = 4'(r_rr_ptr[o]) + 4'(k);
        w_cand = (w_sum >= 4'd5) ? 3'(w_sum - 4'd5) : 3'(w_sum);
        if (w_free[o] && !w_gnt_vld[o] && w_req[o][w_cand]) begin
          w_gnt_vld[o] = 1'b1;
          w_gnt_idx[o] = w_cand;
        end
      end
    end
  end

  // Each input routes to exactly one output, so at most one grant pops it
  always_comb begin
    w_pop = '0;
    for (int o = 0; o < NPORT; o++) begin
      if (w_gnt_vld[o]) begin
        w_pop[w_gnt_idx[o]] = 1'b1;
      end
    end
  end

  // Next occupancy per FIFO; push and pop together leave it unchanged
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      w_cnt_nxt[i] = r_count[i];
      if (w_push[i] && !w_pop[i]) begin
        w_cnt_nxt[i] = r_count[i] + CNT_W'(1);
      end else if (!w_push[i] && w_pop[i]) begin
        w_cnt_nxt[i] = r_count[i] - CNT_W'(1);
      end
    end
  end

  // FIFO storage write port (contents need no reset; pointers gate use)
  always_ff @(posedge clk) begin
    for (int i = 0; i < NPORT; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // FIFO pointers, occupancy and registered not-full flag
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPORT; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      r_in_ready <= '1;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (w_push[i]) begin
          r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
        end
        if (w_pop[i]) begin
          r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
        end
        r_count[i]    <= w_cnt_nxt[i];
        r_in_ready[i] <= (w_cnt_nxt[i] != CNT_W'(DEPTH));
      end
    end
  end

  // Output slot load on grant, drain when free and idle, pointer advance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= '0;
      for (int o = 0; o < NPORT; o++) begin
        r_rr_ptr[o] <= '0;
      end
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        if (w_gnt_vld[o]) begin
          r_out_data[o*DATA_W +: DATA_W] <= w_head[w_gnt_idx[o]];
          r_out_valid[o]                 <= 1'b1;
          r_rr_ptr[o] <= (w_gnt_idx[o] == 3'd4) ? 3'd0 : (w_gnt_idx[o] + 3'd1);
        end else if (w_free[o]) begin
          r_out_valid[o] <= 1'b0;
        end
      end
    end
  end

`ifdef MESH_XY_ROUTER_STATS_EN
  logic [5*STAT_W-1:0] r_stat;

  assign stat_flits = r_stat;

  // Count completed output handshakes per port; wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat <= '0;
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        if (r_out_valid[o] && out_ready[o]) begin
          r_stat[o*STAT_W +: STAT_W] <= r_stat[o*STAT_W +: STAT_W] + STAT_W'(1);
        end
      end
    end
  end
`endif

endmodule
